snake_move_scheduler: RTL and testbench

Sequences the snake game datapath: turns the four raw direction buttons into the `accion` code and a periodic one-cycle `mover` strobe that advances the player box. Sits between the board buttons and the game-logic block, and consumes that block's `comer` (ate fruit) and `reset` (death) outputs. Runs a small game-state FSM, a 2-entry direction queue with reversal rejection, and a move-period timer that speeds up as fruit is eaten.

---
 rtl/snake_move_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_snake_move_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/snake_move_scheduler.sv
// Snake move scheduler: button sync/edge detect, IDLE/RUN/DEAD FSM, 2-entry direction queue, move timer.
// Optional macro SNAKE_SPEEDUP_EN: shorten the move period on each fruit eaten.
module snake_move_scheduler #(
  parameter int unsigned MOVE_PERIOD = 5_000_000,
  parameter int unsigned MIN_PERIOD  = 1_000_000,
  parameter int unsigned SPEED_STEP  = 250_000,
  parameter int unsigned DEAD_HOLD   = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic       uclk,
  input  logic       rst,
  input  logic       BtnTop,
  input  logic       BtnBottom,
  input  logic       BtnLeft,
  input  logic       BtnRight,
  input  logic       comer,
  input  logic       game_reset,
  output logic       mover,
  output logic [2:0] accion,
  output logic [1:0] state,
  output logic [7:0] eat_count
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DEAD = 2'd2} state_t;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  localparam logic [CNT_W-1:0] MOVE_P  = CNT_W'(MOVE_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W:0]   STEP_W  = (CNT_W+1)'(SPEED_STEP);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(DEAD_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef SNAKE_SPEEDUP_EN
  localparam bit SPEEDUP_EN = 1'b1;
`else
  localparam bit SPEEDUP_EN = 1'b0;
`endif

  function automatic logic is_opposite(input logic [2:0] a, input logic [2:0] b);
    case (a)
      DIR_UP:    return b == DIR_DOWN;
      DIR_DOWN:  return b == DIR_UP;
      DIR_LEFT:  return b == DIR_RIGHT;
      DIR_RIGHT: return b == DIR_LEFT;
      default:   return 1'b0;
    endcase
  endfunction

  // Bit 3..0 = Top, Bottom, Left, Right
  logic [3:0]       sync1_q, sync2_q, sync3_q, rise_q;
  state_t           state_q;
  logic             mover_q, comer_q;
  logic [2:0]       accion_q, q0_q, q1_q;
  logic [1:0]       qcnt_q;
  logic [7:0]       eat_q;
  logic [CNT_W-1:0] period_q, tick_q, hold_q;

  logic [2:0]       cand_s, ref_s;
  logic             push_s, tick_hit_s, pop_s, comer_rise_s;
  logic [CNT_W:0]   period_wide_s;
  logic [CNT_W-1:0] period_dec_s;

  // Two-flop synchronizer, then a registered rising-edge detect per button
  always_ff @(posedge uclk) begin
    if (rst) begin
      sync1_q <= 4'd0;
      sync2_q <= 4'd0;
      sync3_q <= 4'd0;
      rise_q  <= 4'd0;
    end else begin
      sync1_q <= {BtnTop, BtnBottom, BtnLeft, BtnRight};
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      rise_q  <= sync2_q & ~sync3_q;
    end
  end

  // Candidate selection, queue acceptance, tick compare and next speed-up period
  always_comb begin
    cand_s = DIR_NONE;
    if (rise_q[3])      cand_s = DIR_UP;
    else if (rise_q[2]) cand_s = DIR_DOWN;
    else if (rise_q[1]) cand_s = DIR_LEFT;
    else if (rise_q[0]) cand_s = DIR_RIGHT;
    else                cand_s = DIR_NONE;

    if (qcnt_q == 2'd2)      ref_s = q1_q;
    else if (qcnt_q == 2'd1) ref_s = q0_q;
    else                     ref_s = accion_q;

    push_s = (cand_s != DIR_NONE) && (qcnt_q != 2'd2) &&
             (cand_s != ref_s) && !is_opposite(cand_s, ref_s);
    tick_hit_s   = tick_q >= (period_q - CNT_ONE);
    pop_s        = tick_hit_s && (qcnt_q != 2'd0);
    comer_rise_s = comer & ~comer_q;

    period_wide_s = {1'b0, period_q} - STEP_W;
    if (period_wide_s[CNT_W] || (period_wide_s[CNT_W-1:0] < MIN_P)) period_dec_s = MIN_P;
    else                                                            period_dec_s = period_wide_s[CNT_W-1:0];
  end

  // Game-state FSM with queue, move timer, speed-up and registered outputs
  always_ff @(posedge uclk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mover_q  <= 1'b0;
      accion_q <= DIR_NONE;
      eat_q    <= 8'd0;
      period_q <= MOVE_P;
      tick_q   <= '0;
      hold_q   <= '0;
      q0_q     <= DIR_NONE;
      q1_q     <= DIR_NONE;
      qcnt_q   <= 2'd0;
      comer_q  <= 1'b0;
    end else begin
      comer_q <= comer;
      mover_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cand_s != DIR_NONE) begin
            state_q  <= ST_RUN;
            accion_q <= cand_s;
            tick_q   <= '0;
            qcnt_q   <= 2'd0;
            eat_q    <= 8'd0;
          end
        end
        ST_RUN: begin
          if (game_reset) begin
            state_q  <= ST_DEAD;
            qcnt_q   <= 2'd0;
            accion_q <= DIR_NONE;
            period_q <= MOVE_P;
            tick_q   <= '0;
            hold_q   <= '0;
          end else begin
            if (tick_hit_s) begin
              tick_q  <= '0;
              mover_q <= 1'b1;
              if (pop_s) accion_q <= q0_q;
            end else begin
              tick_q <= tick_q + CNT_ONE;
            end
            // Push and pop together only happens with one entry queued
            if (pop_s && push_s) begin
              q0_q <= cand_s;
            end else if (pop_s) begin
              q0_q   <= q1_q;
              qcnt_q <= qcnt_q - 2'd1;
            end else if (push_s) begin
              if (qcnt_q == 2'd0) q0_q <= cand_s;
              else                q1_q <= cand_s;
              qcnt_q <= qcnt_q + 2'd1;
            end
            if (comer_rise_s) begin
              if (eat_q != 8'hFF) eat_q <= eat_q + 8'd1;
              if (SPEEDUP_EN) period_q <= period_dec_s;
            end
          end
        end
        ST_DEAD: begin
          if (hold_q >= HOLD_M1) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_q + CNT_ONE;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          accion_q <= DIR_NONE;
          qcnt_q   <= 2'd0;
        end
      endcase
    end
  end

  assign mover     = mover_q;
  assign accion    = accion_q;
  assign state     = state_q;
  assign eat_count = eat_q;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Directed bench for snake_move_scheduler with small timing parameters.
module tb_snake_move_scheduler;

  logic       uclk = 1'b0;
  logic       rst = 1'b1;
  logic       bt = 1'b0, bb = 1'b0, bl = 1'b0, br = 1'b0;
  logic       comer = 1'b0, game_reset = 1'b0;
  logic       mover;
  logic [2:0] accion;
  logic [1:0] state;
  logic [7:0] eat_count;
  int         checks = 0;
  int         failures = 0;

`ifdef SNAKE_SPEEDUP_EN
  localparam bit SPEED = 1'b1;
`else
  localparam bit SPEED = 1'b0;
`endif

  always #5 uclk = ~uclk;

  snake_move_scheduler #(
    .MOVE_PERIOD(10), .MIN_PERIOD(4), .SPEED_STEP(3), .DEAD_HOLD(5), .CNT_W(26)
  ) dut (
    .uclk(uclk), .rst(rst),
    .BtnTop(bt), .BtnBottom(bb), .BtnLeft(bl), .BtnRight(br),
    .comer(comer), .game_reset(game_reset),
    .mover(mover), .accion(accion), .state(state), .eat_count(eat_count)
  );

  task automatic step(input int n);
    repeat (n) @(posedge uclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    step(2);
    check("rst_state", 32'(state), 32'd0);
    check("rst_accion", 32'(accion), 32'd0);
    check("rst_mover", 32'(mover), 32'd0);
    check("rst_eat", 32'(eat_count), 32'd0);
    rst = 1'b0;
    step(3);
    check("idle_mover", 32'(mover), 32'd0);

    // Start with Right: RUN on the 4th edge after the press
    br = 1'b1; step(1); br = 1'b0; step(2);
    check("pre_run_state", 32'(state), 32'd0);
    check("pre_run_mover", 32'(mover), 32'd0);
    step(1);
    check("start_state", 32'(state), 32'd1);
    check("start_accion", 32'(accion), 32'd4);
    step(9);
    check("t9_mover", 32'(mover), 32'd0);
    step(1);
    check("t10_mover", 32'(mover), 32'd1);
    step(1);
    check("t11_mover", 32'(mover), 32'd0);
    step(9);
    check("t20_mover", 32'(mover), 32'd1);

    // Reversal: Left dropped, Top queued and popped at next strobe
    bl = 1'b1; step(1); bl = 1'b0; step(3);
    bt = 1'b1; step(1); bt = 1'b0; step(3);
    step(1);
    check("rev_pre_accion", 32'(accion), 32'd4);
    step(1);
    check("rev_mover", 32'(mover), 32'd1);
    check("rev_accion", 32'(accion), 32'd1);

    // Queue: Left, Top accepted; Right dropped because full
    bl = 1'b1; step(1);
    bl = 1'b0; bt = 1'b1; step(1);
    bt = 1'b0; br = 1'b1; step(1);
    br = 1'b0; step(7);
    check("q1_mover", 32'(mover), 32'd1);
    check("q1_accion", 32'(accion), 32'd3);
    step(9);
    check("q1_hold_accion", 32'(accion), 32'd3);
    check("q1_gap_mover", 32'(mover), 32'd0);
    step(1);
    check("q2_mover", 32'(mover), 32'd1);
    check("q2_accion", 32'(accion), 32'd1);
    step(10);
    check("q3_mover", 32'(mover), 32'd1);
    check("q3_accion", 32'(accion), 32'd1);

    // Speed-up: comer edges at T61, T68, T72
    comer = 1'b1; step(1); comer = 1'b0;
    check("eat1", 32'(eat_count), 32'd1);
    step(5);
    check("sp_t66_mover", 32'(mover), 32'd0);
    step(1);
    check("sp_t67_mover", 32'(mover), SPEED ? 32'd1 : 32'd0);
    comer = 1'b1; step(1); comer = 1'b0;
    check("eat2", 32'(eat_count), 32'd2);
    step(2);
    check("sp_t70_mover", 32'(mover), SPEED ? 32'd0 : 32'd1);
    step(1);
    check("sp_t71_mover", 32'(mover), SPEED ? 32'd1 : 32'd0);
    comer = 1'b1; step(1); comer = 1'b0;
    check("eat3", 32'(eat_count), 32'd3);
    step(2);
    check("sp_t74_mover", 32'(mover), 32'd0);
    step(1);
    check("sp_t75_mover", 32'(mover), SPEED ? 32'd1 : 32'd0);

    // Death on the tick cycle
    step(SPEED ? 3 : 4);
    game_reset = 1'b1; step(1); game_reset = 1'b0;
    check("dead_mover", 32'(mover), 32'd0);
    check("dead_state", 32'(state), 32'd2);
    check("dead_accion", 32'(accion), 32'd0);
    check("dead_eat", 32'(eat_count), 32'd3);
    bt = 1'b1; step(1); bt = 1'b0; step(3);
    check("dead_d4_state", 32'(state), 32'd2);
    step(1);
    check("dead_d5_state", 32'(state), 32'd0);
    check("dead_d5_accion", 32'(accion), 32'd0);
    step(3);
    check("dead_btn_ignored", 32'(state), 32'd0);
    check("idle2_mover", 32'(mover), 32'd0);
    check("idle2_eat", 32'(eat_count), 32'd3);

    // Restart clears eat_count and runs at the initial period
    bb = 1'b1; step(1); bb = 1'b0; step(3);
    check("restart_state", 32'(state), 32'd1);
    check("restart_accion", 32'(accion), 32'd2);
    check("restart_eat", 32'(eat_count), 32'd0);
    step(9);
    check("restart_t9_mover", 32'(mover), 32'd0);
    step(1);
    check("restart_t10_mover", 32'(mover), 32'd1);

    // Reset mid-RUN with a full queue
    comer = 1'b1; step(1); comer = 1'b0;
    bl = 1'b1;
    check("mid_eat", 32'(eat_count), 32'd1);
    step(1); bl = 1'b0; bt = 1'b1;
    step(1); bt = 1'b0;
    step(3);
    check("mid_pre_state", 32'(state), 32'd1);
    check("mid_pre_mover", 32'(mover), 32'd0);
    rst = 1'b1; step(1);
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_accion", 32'(accion), 32'd0);
    check("mid_rst_eat", 32'(eat_count), 32'd0);
    check("mid_rst_mover", 32'(mover), 32'd0);
    rst = 1'b0;
    br = 1'b1; step(1); br = 1'b0; step(3);
    check("post_rst_state", 32'(state), 32'd1);
    check("post_rst_accion", 32'(accion), 32'd4);
    step(9);
    check("post_rst_t9_mover", 32'(mover), 32'd0);
    step(1);
    check("post_rst_t10_mover", 32'(mover), 32'd1);
    check("post_rst_t10_accion", 32'(accion), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
